// File: rtl/shift_seq_pkg.sv
// ============================================================================
//  Module      : shift_seq_pkg
//  Description : Shared op and state encodings for the multi-cycle shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
//  Module      : shift_stage
//  Description : One log-shifter stage: shifts by 2^k with op-selected fill.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   k,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out
);

    logic [SHW:0] w_dist;

    assign w_dist = (SHW+1)'(1) << k;

    always_comb begin
        out = in;
        case (op)
            OP_SLL:  out = in << w_dist;
            OP_SRL:  out = in >> w_dist;
            OP_SRA:  out = $unsigned($signed(in) >>> w_dist);
            default: out = in;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_seq.sv
// ============================================================================
//  Module      : shift_seq
//  Description : Multi-cycle SLL/SRL/SRA unit, one power-of-two stage per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_op;
    logic [SHW-1:0]   r_amt;
    logic [SHW-1:0]   r_k;

    logic [WIDTH-1:0] w_stage_out;
    logic [WIDTH-1:0] w_acc_next;
    logic [SHW-1:0]   w_rest;
    logic             w_accept;
    logic             w_bypass;
    logic             w_last;

    shift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .in  (r_acc),
        .k   (r_k),
        .op  (r_op),
        .out (w_stage_out)
    );

    assign w_accept   = (r_state != S_SHIFT) && start && !flush;
    assign w_bypass   = (shamt == '0) || (op == OP_RSV);
    // Bit 0 of the remaining amount selects this stage; nothing above it means this is the last one.
    assign w_rest     = r_amt >> r_k;
    assign w_last     = (w_rest[SHW-1:1] == '0);
    assign w_acc_next = w_rest[0] ? w_stage_out : r_acc;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_state_next = w_bypass ? S_DONE : S_SHIFT;
                else
                    w_state_next = S_IDLE;
            end
            S_SHIFT: begin
                if (flush)
                    w_state_next = S_IDLE;
                else if (w_last)
                    w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_result <= '0;
            r_op     <= '0;
            r_amt    <= '0;
            r_k      <= '0;
        end else if (w_accept) begin
            r_acc <= a;
            r_op  <= op;
            r_amt <= shamt;
            r_k   <= '0;
            if (w_bypass)
                r_result <= a;
        end else if (r_state == S_SHIFT && !flush) begin
            r_acc <= w_acc_next;
            if (w_last)
                r_result <= w_acc_next;
            else
                r_k <= r_k + SHW'(1);
        end
    end

    assign busy   = (r_state == S_SHIFT);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
// ============================================================================
//  Module      : tb_shift_seq
//  Description : Self-checking bench for shift_seq with a cycle-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .shamt  (shamt),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x,
                                              input logic [4:0] s);
        logic [31:0] r;
        case (o)
            2'b00:   r = x << s;
            2'b01:   r = x >> s;
            2'b10:   r = $unsigned($signed(x) >>> s);
            default: r = x;
        endcase
        return r;
    endfunction

    // Cycles spent busy = index of the highest set amount bit, plus one.
    function automatic int stages(input logic [4:0] s);
        int n = 0;
        for (int i = 0; i < 5; i++)
            if (s[i]) n = i + 1;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a countdown of remaining busy cycles plus the arithmetic result.
    bit          m_valid = 0;
    int          m_left  = 0;
    bit          m_done  = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1;
            m_left   = 0;
            m_done   = 0;
            m_result = '0;
        end else if (m_left > 0) begin
            m_done = 0;
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done   = 1;
                    m_result = m_pend;
                end
            end
        end else begin
            m_done = 0;
            if (start && !flush) begin
                m_pend = ref_shift(op, a, shamt);
                if (shamt == 0 || op == 2'b11) begin
                    m_done   = 1;
                    m_result = a;
                end else begin
                    m_left = stages(shamt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model busy",   {31'b0, busy}, {31'b0, (m_left > 0)});
            check("model done",   {31'b0, done}, {31'b0, m_done});
            check("model result", result, m_result);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s);
        start = 1'b1;
        op    = o;
        a     = x;
        shamt = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // cyc0 is the cycle index (N+cyc0) the caller is currently sitting in.
    task automatic wait_done(input string name, input int cyc0, input int exp_lat,
                             input logic [31:0] exp_res);
        int cyc = cyc0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, " done seen"}, {31'b0, done}, 32'd1);
        check({name, " latency"}, cyc, exp_lat);
        check({name, " result"}, result, exp_res);
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        flush = 1'b0;
        op    = 2'b00;
        a     = 32'hFFFF_FFFF;
        shamt = 5'd3;
        idle(2);
        check("reset busy",   {31'b0, busy}, 32'd0);
        check("reset done",   {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        idle(1);
        check("post-reset busy", {31'b0, busy}, 32'd0);
        check("post-reset done", {31'b0, done}, 32'd0);

        issue(2'b01, 32'h8000_0000, 5'd31);
        check("srl31 busy at N+1", {31'b0, busy}, 32'd1);
        wait_done("srl31", 1, 6, 32'h0000_0001);
        idle(1);
        check("srl31 hold result", result, 32'h0000_0001);
        check("srl31 done cleared", {31'b0, done}, 32'd0);

        issue(2'b10, 32'hF000_0000, 5'd5);
        wait_done("sra5", 1, 4, 32'hFF80_0000);
        idle(1);

        issue(2'b00, 32'h0000_0001, 5'd4);
        wait_done("sll4", 1, 4, 32'h0000_0010);
        idle(1);

        issue(2'b00, 32'h1234_5678, 5'd0);
        check("sh0 busy", {31'b0, busy}, 32'd0);
        wait_done("sh0", 1, 1, 32'h1234_5678);
        idle(1);

        issue(2'b11, 32'hCAFE_BABE, 5'd7);
        check("rsv busy", {31'b0, busy}, 32'd0);
        wait_done("rsv", 1, 1, 32'hCAFE_BABE);
        idle(1);

        // Back-to-back: second start lands in the first op's DONE cycle.
        issue(2'b01, 32'h0000_0100, 5'd8);
        wait_done("b2b first", 1, 5, 32'h0000_0001);
        issue(2'b00, 32'h0000_0001, 5'd16);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h0000_FFFF;
        shamt = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b second", 2, 6, 32'h0001_0000);
        idle(1);

        issue(2'b01, 32'h8000_0000, 5'd31);
        idle(1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("flush busy",   {31'b0, busy}, 32'd0);
        check("flush done",   {31'b0, done}, 32'd0);
        check("flush result", result, 32'h0001_0000);
        idle(8);
        check("flush no late result", result, 32'h0001_0000);

        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        a     = 32'h0000_0005;
        shamt = 5'd0;
        idle(1);
        start = 1'b0;
        flush = 1'b0;
        check("idle flush done",   {31'b0, done}, 32'd0);
        check("idle flush result", result, 32'h0001_0000);

        issue(2'b10, 32'h8000_0000, 5'd31);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid rst busy",   {31'b0, busy}, 32'd0);
        check("mid rst done",   {31'b0, done}, 32'd0);
        check("mid rst result", result, 32'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
